// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined main memory between I-cache block fills, D-cache block
// fills (round-robin) and D-cache single-word write-through stores (highest priority).
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_fill_req,
  input  logic [15:0]                    i_fill_addr,
  output logic                           i_fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] i_fill_word,
  output logic                           i_fill_done,
  input  logic                           d_fill_req,
  input  logic [15:0]                    d_fill_addr,
  output logic                           d_fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] d_fill_word,
  output logic                           d_fill_done,
  output logic [15:0]                    fill_data,
  input  logic                           d_wr_req,
  input  logic [15:0]                    d_wr_addr,
  input  logic [15:0]                    d_wr_data,
  output logic                           d_wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid,
  output logic                           busy
);
  localparam int              IDXW      = $clog2(BLOCK_WORDS);
  localparam logic [15:0]     BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);
  localparam logic [IDXW-1:0] LAST_WORD = IDXW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e          state_q;
  owner_e          owner_q;
  owner_e          last_fill_q;
  logic [IDXW:0]   ic_q;
  logic [IDXW-1:0] rc_q;
  logic [15:0]     base_q;

  logic grant_dcache;
  logic issuing;
  logic fill_valid;

  // D wins a contested fill unless it was the most recent fill owner.
  assign grant_dcache = d_fill_req && (!i_fill_req || last_fill_q == OWN_I);
  // The extra top bit of ic_q sets once every word of the block has been issued.
  assign issuing      = (state_q == S_FILL) && !ic_q[IDXW];
  assign fill_valid   = (state_q == S_FILL) && mem_data_valid;
  assign fill_data    = mem_data_out;
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      last_fill_q <= OWN_I;
      ic_q        <= '0;
      rc_q        <= '0;
      base_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      unique case (state_q)
        S_IDLE: begin
          ic_q <= '0;
          rc_q <= '0;
          if (d_wr_req) begin
            state_q <= S_WRITE;
          end else if (i_fill_req || d_fill_req) begin
            state_q <= S_FILL;
            if (grant_dcache) begin
              owner_q <= OWN_D;
              base_q  <= d_fill_addr & BASE_MASK;
            end else begin
              owner_q <= OWN_I;
              base_q  <= i_fill_addr & BASE_MASK;
            end
          end
        end
        S_FILL: begin
          if (!ic_q[IDXW]) ic_q <= ic_q + 1'b1;
          if (mem_data_valid) begin
            rc_q <= rc_q + 1'b1;
            if (rc_q == LAST_WORD) begin
              state_q     <= S_IDLE;
              last_fill_q <= owner_q;
              owner_q     <= OWN_NONE;
            end
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    d_wr_ack    = 1'b0;
    i_fill_we   = 1'b0;
    i_fill_word = '0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_word = '0;
    d_fill_done = 1'b0;

    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = base_q + 16'({ic_q[IDXW-1:0], 1'b0});
    end else if (state_q == S_WRITE) begin
      mem_en      = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = d_wr_addr;
      mem_data_in = d_wr_data;
      d_wr_ack    = 1'b1;
    end

    if (fill_valid && owner_q == OWN_I) begin
      i_fill_we   = 1'b1;
      i_fill_word = rc_q;
      i_fill_done = (rc_q == LAST_WORD);
    end
    if (fill_valid && owner_q == OWN_D) begin
      d_fill_we   = 1'b1;
      d_fill_word = rc_q;
      d_fill_done = (rc_q == LAST_WORD);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-4 memory model, cycle-stamped event log,
// per-fill address/data/timing checks, priority, round-robin, reset abort and wrap.
module tb_mem_arbiter;
  localparam int K_ISS = 0;
  localparam int K_WEI = 1;
  localparam int K_WED = 2;
  localparam int K_WR  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
    logic [2:0]  w;
    logic        done;
  } ev_t;

  logic        clk, rst_n;
  logic        i_fill_req, i_fill_we, i_fill_done;
  logic [15:0] i_fill_addr;
  logic [2:0]  i_fill_word;
  logic        d_fill_req, d_fill_we, d_fill_done;
  logic [15:0] d_fill_addr;
  logic [2:0]  d_fill_word;
  logic [15:0] fill_data;
  logic        d_wr_req, d_wr_ack;
  logic [15:0] d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_data_valid, busy;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  bit   busy_h [1024];
  ev_t  ev_q [$];

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr), .i_fill_we(i_fill_we),
    .i_fill_word(i_fill_word), .i_fill_done(i_fill_done),
    .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr), .d_fill_we(d_fill_we),
    .d_fill_word(d_fill_word), .d_fill_done(d_fill_done),
    .fill_data(fill_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns (address ^ 0x5A5A) four cycles after a read issue; it has no reset.
  logic [3:0]  v_pipe = '0;
  logic [15:0] a_pipe [4];
  always @(posedge clk) begin
    v_pipe    <= {v_pipe[2:0], mem_en & ~mem_wr};
    a_pipe[0] <= mem_addr;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    a_pipe[3] <= a_pipe[2];
  end
  assign mem_data_valid = v_pipe[3];
  assign mem_data_out   = a_pipe[3] ^ 16'h5A5A;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'b0, mem_en, mem_wr, mem_addr, mem_data_in, i_fill_we, i_fill_word, i_fill_done,
            d_fill_we, d_fill_word, d_fill_done, d_wr_ack, busy};
  endfunction

  task automatic push_ev(input int kind, input logic [15:0] a, input logic [15:0] d,
                         input logic [2:0] w, input logic dn);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.a = a; e.d = d; e.w = w; e.done = dn;
    ev_q.push_back(e);
  endtask

  // One cycle: sample at the falling edge, log events, and let requesters drop on done/ack.
  task automatic step();
    @(negedge clk);
    if (mem_en && !mem_wr) push_ev(K_ISS, mem_addr, 16'h0, 3'd0, 1'b0);
    if (mem_en && mem_wr)  push_ev(K_WR, mem_addr, mem_data_in, 3'd0, d_wr_ack);
    if (i_fill_we)         push_ev(K_WEI, 16'h0, fill_data, i_fill_word, i_fill_done);
    if (d_fill_we)         push_ev(K_WED, 16'h0, fill_data, d_fill_word, d_fill_done);
    if ((i_fill_done && !i_fill_we) || (d_fill_done && !d_fill_we) ||
        (d_wr_ack && !(mem_en && mem_wr)) || (i_fill_we && d_fill_we)) n_bad++;
    if (cyc < 1024) busy_h[cyc] = busy;
    if (i_fill_done) i_fill_req = 1'b0;
    if (d_fill_done) d_fill_req = 1'b0;
    if (d_wr_ack)    d_wr_req   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Fill granted by the IDLE sample at cycle t0: issues t0+1..t0+8, data t0+5..t0+12.
  task automatic check_fill(input string tag, input bit is_d, input logic [15:0] base, input int t0);
    int          n_iss = 0;
    int          n_we  = 0;
    int          n_oth = 0;
    int          n_busy = 0;
    int          own;
    int          oth;
    logic [15:0] ea;
    own = is_d ? K_WED : K_WEI;
    oth = is_d ? K_WEI : K_WED;
    foreach (ev_q[i]) begin
      if (ev_q[i].cyc >= t0 + 1 && ev_q[i].cyc <= t0 + 12) begin
        if (ev_q[i].kind == K_ISS) begin
          if (n_iss < 8) begin
            ea = base + 16'(2 * n_iss);
            check($sformatf("%s issue%0d addr", tag, n_iss), ev_q[i].a, ea);
            check($sformatf("%s issue%0d cycle", tag, n_iss), ev_q[i].cyc, t0 + 1 + n_iss);
          end
          n_iss++;
        end else if (ev_q[i].kind == own) begin
          if (n_we < 8) begin
            ea = (base + 16'(2 * n_we)) ^ 16'h5A5A;
            check($sformatf("%s we%0d word", tag, n_we), ev_q[i].w, n_we);
            check($sformatf("%s we%0d data", tag, n_we), ev_q[i].d, ea);
            check($sformatf("%s we%0d cycle", tag, n_we), ev_q[i].cyc, t0 + 5 + n_we);
            check($sformatf("%s we%0d done", tag, n_we), ev_q[i].done, n_we == 7);
          end
          n_we++;
        end else if (ev_q[i].kind == oth) begin
          n_oth++;
        end
      end
    end
    for (int c = t0 + 1; c <= t0 + 12; c++) n_busy += int'(busy_h[c]);
    check({tag, " issue count"}, n_iss, 8);
    check({tag, " owner we count"}, n_we, 8);
    check({tag, " other we count"}, n_oth, 0);
    check({tag, " busy cycles"}, n_busy, 12);
    check({tag, " idle before"}, busy_h[t0], 0);
    check({tag, " idle after"}, busy_h[t0 + 13], 0);
  endtask

  task automatic check_write(input string tag, input int t_from, input int t_to, input int t_exp);
    int n_wr = 0;
    foreach (ev_q[i]) begin
      if (ev_q[i].kind == K_WR && ev_q[i].cyc >= t_from && ev_q[i].cyc <= t_to) begin
        check({tag, " addr"}, ev_q[i].a, 16'h00A6);
        check({tag, " data"}, ev_q[i].d, 16'hBEEF);
        check({tag, " ack"}, ev_q[i].done, 1);
        check({tag, " cycle"}, ev_q[i].cyc, t_exp);
        n_wr++;
      end
    end
    check({tag, " count"}, n_wr, 1);
  endtask

  initial begin
    int t0;
    int t1;
    int n_late;
    rst_n = 1'b0;
    i_fill_req = 1'b0; i_fill_addr = '0;
    d_fill_req = 1'b0; d_fill_addr = '0;
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    #1 check("reset outputs", outs(), 64'h0);
    do_reset();

    // Single D fill with an unaligned address.
    d_fill_addr = 16'h1234; d_fill_req = 1'b1; t0 = cyc;
    repeat (14) step();
    check_fill("d fill", 1'b1, 16'h1230, t0);

    // Contested fills after reset: D first, I granted in the IDLE cycle after D's done.
    do_reset();
    i_fill_addr = 16'h0456; d_fill_addr = 16'h0788;
    i_fill_req = 1'b1; d_fill_req = 1'b1; t0 = cyc;
    repeat (28) step();
    check_fill("contest d", 1'b1, 16'h0780, t0);
    check_fill("contest i", 1'b0, 16'h0450, t0 + 13);

    // Store and D fill arrive mid I fill: write goes first, then the D fill.
    step();
    i_fill_addr = 16'h0400; i_fill_req = 1'b1; t0 = cyc;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 3) begin
        d_wr_addr = 16'h00A6; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        d_fill_addr = 16'h2000; d_fill_req = 1'b1;
      end
    end
    check_fill("wr-prio i", 1'b0, 16'h0400, t0);
    check_write("wr-prio write", t0 + 1, t0 + 30, t0 + 14);
    check_fill("wr-prio d", 1'b1, 16'h2000, t0 + 15);

    // Round-robin: D re-requests right after its fill, I still pending -> D, I, D.
    do_reset();
    i_fill_addr = 16'h0800; d_fill_addr = 16'h0900;
    i_fill_req = 1'b1; d_fill_req = 1'b1; t0 = cyc;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 13) begin
        d_fill_addr = 16'h0A00; d_fill_req = 1'b1;
      end
    end
    check_fill("rr d1", 1'b1, 16'h0900, t0);
    check_fill("rr i", 1'b0, 16'h0800, t0 + 13);
    check_fill("rr d2", 1'b1, 16'h0A00, t0 + 26);

    // Reset during the fifth issue cycle abandons the fill.
    step();
    d_fill_addr = 16'h3000; d_fill_req = 1'b1; t0 = cyc;
    repeat (5) step();
    rst_n = 1'b0; d_fill_req = 1'b0;
    #1 check("mid-fill reset outputs", outs(), 64'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    n_late = 0;
    foreach (ev_q[i])
      if (ev_q[i].cyc >= t0 + 6 && ev_q[i].cyc <= t0 + 13 && ev_q[i].kind != K_WR) n_late++;
    check("abort no late events", n_late, 0);
    t1 = cyc;
    d_fill_req = 1'b1;
    repeat (14) step();
    check_fill("after reset", 1'b1, 16'h3000, t1);

    // Top-of-memory block: addresses stay within 16 bits.
    step();
    d_fill_addr = 16'hFFF7; d_fill_req = 1'b1; t0 = cyc;
    repeat (14) step();
    check_fill("wrap", 1'b1, 16'hFFF0, t0);

    check("protocol strobes", n_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory controller between the instruction cache, the data cache and the single multicycle main memory (memory4c: 16-bit words, pipelined, fixed read latency, `data_valid` strobe). It grants the memory to one requester at a time, sequences 8-word block fills for cache misses, and performs single-word write-through stores for the data cache. Caches stall on their own request until it completes; the arbiter owns every memory control signal.

## Interface

- `BLOCK_WORDS`, default 8: 16-bit words per cache block. Power of two. Block size is 2·`BLOCK_WORDS` bytes.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_fill_req`  in  1  I-cache miss; held high until `i_fill_done`.
- `i_fill_addr`  in  16  I-cache miss byte address; stable while `i_fill_req` is high.
- `i_fill_we`  out  1  word write strobe into the I-cache data array.
- `i_fill_word`  out  log2(`BLOCK_WORDS`)  word index within the block for `i_fill_we`.
- `i_fill_done`  out  1  one-cycle pulse marking the last fill word.
- `d_fill_req`, `d_fill_addr`, `d_fill_we`, `d_fill_word`, `d_fill_done`: same as the I-cache signals, for the D-cache.
- `fill_data`  out  16  fill word, shared by both caches; valid with either `*_fill_we`.
- `d_wr_req`  in  1  D-cache write-through; held until `d_wr_ack`.
- `d_wr_addr`  in  16  store byte address.
- `d_wr_data`  in  16  store data.
- `d_wr_ack`  out  1  one-cycle pulse; the write is issued to memory in this cycle.
- `mem_en`  out  1  memory enable.
- `mem_wr`  out  1  memory write.
- `mem_addr`  out  16  memory byte address.
- `mem_data_in`  out  16  write data to memory.
- `mem_data_out`  in  16  read data from memory.
- `mem_data_valid`  in  1  read data valid.
- `busy`  out  1  high in FILL or WRITE.

## Operation

- States: IDLE, FILL, WRITE. Reset enters IDLE.
- IDLE: requests are sampled. Priority:
  1. `d_wr_req` → WRITE.
  2. Fill requests, round-robin by a `last_fill` pointer. On reset the pointer favours D.
  - If only one fill request is pending, it wins.
  - The owner is latched, and `base` = fill_addr with the low log2(2·`BLOCK_WORDS`) bits cleared.
  - If no request is pending, stay in IDLE.
- FILL:
  - Issue counter `ic` runs 0..`BLOCK_WORDS`-1. While `ic` < `BLOCK_WORDS`: `mem_en`=1, `mem_wr`=0, `mem_addr` = `base` + 2·`ic`, and `ic` increments each cycle.
  - Receive counter `rc` counts `mem_data_valid` pulses.
  - Each valid produces owner `*_fill_we`=1, `*_fill_word`=`rc`, and `fill_data`=`mem_data_out` (combinational pass-through).
  - On the valid with `rc`=`BLOCK_WORDS`-1, the owner's `*_fill_done`=1 in the same cycle. Next state is IDLE, and `last_fill` is set to the owner.
- WRITE (one cycle):
  - `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_wr_addr`, `mem_data_in`=`d_wr_data`, `d_wr_ack`=1.
  - Next state is IDLE.
- `mem_en`, `mem_wr`, `mem_addr`, `mem_data_in` and `busy` derive only from registered state and counters. There is no combinational path from the `*_req` inputs. The exception is `mem_addr`/`mem_data_in` in WRITE, which pass `d_wr_addr`/`d_wr_data` through.
- Outside FILL, `mem_data_valid` is ignored, and so are extra valids after `rc` wraps. Non-owner fill strobes stay 0.
- Requests arriving in FILL or WRITE wait; they are sampled at the next IDLE.
- A requester must drop `*_req` in the cycle after its done/ack. A request still high then is treated as a new request.
- Address arithmetic is 16-bit and wraps modulo 2^16 (base 0xFFF0 issues 0xFFF0..0xFFFE).

## Timing

- Reset (asynchronous, immediate): state IDLE, `ic`=`rc`=0, owner cleared, `last_fill`=I.
  - With `last_fill`=I, the next contested fill goes to D.
  - All outputs are 0: `mem_en`, `mem_wr`, `mem_addr`, `mem_data_in`, all `*_fill_we`/`*_fill_word`/`*_fill_done`, `d_wr_ack`, `busy`.
  - `fill_data` follows `mem_data_out` but is qualified by `*_fill_we`=0.
- Reset mid-FILL: the in-flight fill is abandoned and no done is issued. Late `mem_data_valid` after reset produces no `*_fill_we`.
- Fill (memory latency 4): request sampled in IDLE at cycle N.
  - Issue cycles N+1..N+8.
  - Data/`*_fill_we` at N+5..N+12.
  - `*_fill_done` at N+12; IDLE at N+13.
  - Total 12 busy cycles.
- Write: sampled at N, WRITE/`d_wr_ack` at N+1, IDLE at N+2.
- Back-to-back: minimum one IDLE cycle between grants.

## Test plan

- D fill, `d_fill_addr`=0x1234 → `mem_addr` 0x1230,0x1232,…,0x123E on 8 consecutive cycles. Eight `d_fill_we` pulses with words 0..7 and data matching memory. `d_fill_done` with word 7. `i_fill_we` stays 0 throughout.
- I and D fills raised together after reset → D served first. I is granted in the IDLE cycle after `d_fill_done`, and I's issue starts one cycle after that grant.
- `d_wr_req` (addr 0x00A6, data 0xBEEF) raised mid-I-fill while `d_fill_req` is also pending → write waits. After `i_fill_done`, WRITE comes first: one cycle of `mem_en`=`mem_wr`=1 at 0x00A6 with 0xBEEF and `d_wr_ack`. Then the D fill.
- D fills back-to-back with I pending → grant order D, I, D (round-robin; no I starvation).
- Assert `rst_n`=0 at fill issue cycle 5 → all outputs 0 immediately. Remaining memory valids produce no `*_fill_we`/`*_fill_done`. A new fill afterwards completes normally.
- `d_fill_addr`=0xFFF7 → issue 0xFFF0..0xFFFE, no overflow beyond 16 bits.
